snoop_bus_arbiter: RTL and testbench

Parametrised shared-bus arbiter and snoop broadcaster for an N-core coherent system. It grants the single shared bus to one requesting core at a time using round-robin priority, with a bounded tenure. It broadcasts the owner's address and operation to every other core's snoop port, and returns the OR of their hit flags to the owner. When a snooper flushes a dirty line, it routes the flush data to the owner and to a memory write-back port.

---
 rtl/snoop_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
//   Round-robin arbiter for a shared snooping bus with a bounded tenure.
//   The current owner's address and operation are broadcast to every other
//   core. The OR of the snoopers' hit flags is returned to the owner. Flush
//   data from the lowest-index flushing snooper is routed to the owner and
//   to the memory write-back port. An owner eviction flush takes precedence
//   on the write-back port.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   req_core               per-core bus request
//   grant, busy, owner_id  registered grant state
//   core_*_out             per-core bus / snoop response inputs (slice i = core i)
//   core_*_in              per-core data / snoop broadcast outputs
//   mem_wr_en/address/wdata  memory write-back port
module snoop_bus_arbiter #(
    parameter int NUM_CORES  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_HOLD   = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            req_core,
    output logic [NUM_CORES-1:0]            grant,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] core_data_out,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_address_out,
    input  logic [NUM_CORES*2-1:0]          core_operation_out,
    input  logic [NUM_CORES-1:0]            core_cache_hit_out,
    input  logic [NUM_CORES-1:0]            core_flush_out,
    output logic [NUM_CORES*DATA_WIDTH-1:0] core_data_in,
    output logic [NUM_CORES*ADDR_WIDTH-1:0] core_address_in,
    output logic [NUM_CORES*2-1:0]          core_operation_in,
    output logic [NUM_CORES-1:0]            core_cache_hit_in,
    output logic                            mem_wr_en,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic [$clog2(NUM_CORES)-1:0]    owner_id,
    output logic                            busy
);
    localparam int OW = $clog2(NUM_CORES);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [OW-1:0] LAST_INIT = OW'(NUM_CORES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_r;
    logic [OW-1:0]          last_owner_r;
    logic [HW-1:0]          hold_cnt_r;

    logic                   any_req_s;
    logic [OW-1:0]          winner_s;
    logic [NUM_CORES-1:0]   winner_oh_s;
    logic                   owner_req_s;
    logic                   owner_flush_s;
    logic [ADDR_WIDTH-1:0]  owner_addr_s;
    logic [1:0]             owner_op_s;
    logic [DATA_WIDTH-1:0]  owner_data_s;
    logic                   hit_any_s;
    logic                   flush_any_s;
    logic [DATA_WIDTH-1:0]  flush_data_s;

    // Round-robin search: first requester after last_owner_r, with wrap.
    always_comb begin
        any_req_s   = 1'b0;
        winner_s    = '0;
        winner_oh_s = '0;
        for (int off = 1; off <= NUM_CORES; off++) begin
            if (!any_req_s && req_core[(int'(last_owner_r) + off) % NUM_CORES]) begin
                any_req_s = 1'b1;
                winner_s  = OW'((int'(last_owner_r) + off) % NUM_CORES);
            end else begin
                any_req_s = any_req_s;
            end
        end
        winner_oh_s[winner_s] = any_req_s;
    end

    // Pick out the owner's own request, flush, address, operation and data.
    always_comb begin
        owner_req_s   = 1'b0;
        owner_flush_s = 1'b0;
        owner_addr_s  = '0;
        owner_op_s    = 2'b11;
        owner_data_s  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (OW'(i) == owner_id) begin
                owner_req_s   = req_core[i];
                owner_flush_s = core_flush_out[i];
                owner_addr_s  = core_address_out[i*ADDR_WIDTH +: ADDR_WIDTH];
                owner_op_s    = core_operation_out[i*2 +: 2];
                owner_data_s  = core_data_out[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                owner_req_s = owner_req_s;
            end
        end
    end

    // Combine snooper responses: OR of hits, lowest-index flusher supplies data.
    always_comb begin
        hit_any_s    = 1'b0;
        flush_any_s  = 1'b0;
        flush_data_s = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (OW'(i) != owner_id) begin
                hit_any_s = hit_any_s | core_cache_hit_out[i];
                if (core_flush_out[i] && !flush_any_s) begin
                    flush_any_s  = 1'b1;
                    flush_data_s = core_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    flush_any_s = flush_any_s;
                end
            end else begin
                hit_any_s = hit_any_s;
            end
        end
    end

    // Broadcast, hit/data return and write-back; everything quiet while idle.
    always_comb begin
        core_data_in      = '0;
        core_address_in   = '0;
        core_operation_in = {NUM_CORES{2'b11}};
        core_cache_hit_in = '0;
        mem_wr_en         = 1'b0;
        mem_address       = '0;
        mem_wdata         = '0;
        if (busy) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (OW'(i) == owner_id) begin
                    core_data_in[i*DATA_WIDTH +: DATA_WIDTH] = flush_data_s;
                    core_cache_hit_in[i]                     = hit_any_s;
                end else begin
                    core_address_in[i*ADDR_WIDTH +: ADDR_WIDTH] = owner_addr_s;
                    core_operation_in[i*2 +: 2]                 = owner_op_s;
                end
            end
            mem_wr_en   = owner_flush_s | flush_any_s;
            mem_address = owner_addr_s;
            // An owner eviction wins the write-back port over snooper flush data.
            mem_wdata   = owner_flush_s ? owner_data_s : flush_data_s;
        end else begin
            mem_wr_en = 1'b0;
        end
    end

    // Grant FSM: one tenure at a time, forced release after MAX_HOLD cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            grant        <= '0;
            busy         <= 1'b0;
            owner_id     <= '0;
            last_owner_r <= LAST_INIT;
            hold_cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r      <= BUSY;
                        grant        <= winner_oh_s;
                        busy         <= 1'b1;
                        owner_id     <= winner_s;
                        last_owner_r <= winner_s;
                        hold_cnt_r   <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // Release and forced release lead to the same dead cycle.
                    if (!owner_req_s || (hold_cnt_r == HOLD_LAST)) begin
                        state_r <= IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter (4 cores, MAX_HOLD = 4).
// A behavioural model tracks who owns the bus and how long it has held it;
// expected broadcast/hit/data/write-back values are derived from the model
// and the current inputs every cycle.
module tb_snoop_bus_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_core;
    logic [N-1:0]    grant;
    logic [N*DW-1:0] core_data_out;
    logic [N*AW-1:0] core_address_out;
    logic [N*2-1:0]  core_operation_out;
    logic [N-1:0]    core_cache_hit_out;
    logic [N-1:0]    core_flush_out;
    logic [N*DW-1:0] core_data_in;
    logic [N*AW-1:0] core_address_in;
    logic [N*2-1:0]  core_operation_in;
    logic [N-1:0]    core_cache_hit_in;
    logic            mem_wr_en;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_wdata;
    logic [1:0]      owner_id;
    logic            busy;

    int compare_count  = 0;
    int mismatch_count = 0;

    // Reference model state
    bit m_busy;
    int m_owner;
    int m_last;
    int m_held;

    snoop_bus_arbiter #(
        .NUM_CORES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_HOLD(MH)
    ) dut (
        .clk(clk), .reset(reset), .req_core(req_core), .grant(grant),
        .core_data_out(core_data_out), .core_address_out(core_address_out),
        .core_operation_out(core_operation_out),
        .core_cache_hit_out(core_cache_hit_out), .core_flush_out(core_flush_out),
        .core_data_in(core_data_in), .core_address_in(core_address_in),
        .core_operation_in(core_operation_in), .core_cache_hit_in(core_cache_hit_in),
        .mem_wr_en(mem_wr_en), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .owner_id(owner_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        compare_count++;
        if (actual !== expected) begin
            mismatch_count++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] data_of(input int i);
        return core_data_out[i*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] addr_of(input int i);
        return core_address_out[i*AW +: AW];
    endfunction

    function automatic logic [1:0] op_of(input int i);
        return core_operation_out[i*2 +: 2];
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = N - 1;
        m_held  = 0;
    endtask

    // One clock edge of the arbitration rules.
    task automatic model_step();
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (!m_busy && req_core[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end else if (!req_core[m_owner] || m_held == MH) begin
            m_busy = 1'b0;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_all();
        logic [N-1:0]    e_grant;
        logic [N-1:0]    e_hit;
        logic [N*DW-1:0] e_data;
        logic [N*AW-1:0] e_addr;
        logic [N*2-1:0]  e_op;
        logic [DW-1:0]   src;
        bit              have_src;
        bit              hit_any;
        bit              e_wr;
        e_grant  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        e_hit    = '0;
        e_data   = '0;
        e_addr   = '0;
        e_op     = '1;
        src      = '0;
        have_src = 1'b0;
        hit_any  = 1'b0;
        e_wr     = 1'b0;
        if (m_busy) begin
            for (int j = N - 1; j >= 0; j--) begin
                if (j != m_owner && core_flush_out[j]) begin
                    src      = data_of(j);
                    have_src = 1'b1;
                end
            end
            for (int j = 0; j < N; j++) begin
                if (j != m_owner) begin
                    hit_any          = hit_any | core_cache_hit_out[j];
                    e_addr[j*AW +: AW] = addr_of(m_owner);
                    e_op[j*2 +: 2]     = op_of(m_owner);
                end
            end
            e_hit[m_owner]           = hit_any;
            e_data[m_owner*DW +: DW] = src;
            e_wr = have_src || core_flush_out[m_owner];
        end
        check_value("grant", 128'(grant), 128'(e_grant));
        check_value("busy", 128'(busy), 128'(m_busy));
        check_value("op_in", 128'(core_operation_in), 128'(e_op));
        check_value("addr_in", 128'(core_address_in), 128'(e_addr));
        check_value("hit_in", 128'(core_cache_hit_in), 128'(e_hit));
        check_value("data_in", 128'(core_data_in), 128'(e_data));
        check_value("mem_wr_en", 128'(mem_wr_en), 128'(e_wr));
        if (m_busy) begin
            check_value("owner_id", 128'(owner_id), 128'(m_owner));
            check_value("mem_address", 128'(mem_address), 128'(addr_of(m_owner)));
            check_value("mem_wdata", 128'(mem_wdata),
                        128'(core_flush_out[m_owner] ? data_of(m_owner) : src));
        end
    endtask

    // Called shortly after a rising edge; ends shortly after the next one.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic zero_inputs();
        core_data_out      = '0;
        core_address_out   = '0;
        core_operation_out = '0;
        core_cache_hit_out = '0;
        core_flush_out     = '0;
    endtask

    // Reset asserted between edges must clear the grant at once.
    task automatic pulse_reset();
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_value("rst_async_grant", 128'(grant), 128'(0));
        check_value("rst_async_busy", 128'(busy), 128'(0));
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(3) == 0) req_core[i] = ~req_core[i];
            core_flush_out[i] = ($urandom_range(3) == 0);
        end
        core_data_out      = {$urandom, $urandom, $urandom, $urandom};
        core_address_out   = {$urandom, $urandom, $urandom, $urandom};
        core_operation_out = 8'($urandom);
        core_cache_hit_out = 4'($urandom);
    endtask

    initial begin
        reset    = 1'b1;
        req_core = '0;
        zero_inputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_value("rst_grant", 128'(grant), 128'(0));
        check_value("rst_owner", 128'(owner_id), 128'(0));
        check_value("rst_mem_wr", 128'(mem_wr_en), 128'(0));
        check_value("rst_op_in", 128'(core_operation_in), 128'(8'hFF));
        check_all();
        reset = 1'b0;

        // Single requester: core 0 wins first and its op/address reach core 1.
        req_core = 4'b0001;
        core_address_out[31:0]  = 32'h0000_0100;
        core_operation_out[1:0] = 2'b10;
        tick();
        #1;
        check_value("t1_grant", 128'(grant), 128'(4'b0001));
        check_value("t1_owner", 128'(owner_id), 128'(0));
        check_value("t1_op_core1", 128'(core_operation_in[3:2]), 128'(2'b10));
        check_value("t1_addr_core1", 128'(core_address_in[63:32]), 128'(32'h0000_0100));
        check_value("t1_op_core0", 128'(core_operation_in[1:0]), 128'(2'b11));

        // All cores requesting: four-cycle tenures separated by one dead cycle.
        req_core = 4'b1111;
        zero_inputs();
        pulse_reset();
        for (int t = 0; t < 21; t++) begin
            logic [N-1:0] exp_g;
            exp_g = ((t % 5) < 4) ? (4'b0001 << ((t / 5) % N)) : 4'b0000;
            tick();
            check_value("rotation", 128'(grant), 128'(exp_g));
        end

        // Owner 2 snooped by core 3 with a dirty hit, then core 1, then owner eviction.
        req_core = 4'b0100;
        zero_inputs();
        pulse_reset();
        tick();
        core_address_out[95:64]   = 32'h0000_0040;
        core_operation_out[5:4]   = 2'b00;
        core_cache_hit_out        = 4'b1000;
        core_flush_out            = 4'b1000;
        core_data_out[127:96]     = 32'hDEAD_BEEF;
        #1;
        check_value("fl_hit", 128'(core_cache_hit_in), 128'(4'b0100));
        check_value("fl_data2", 128'(core_data_in[95:64]), 128'(32'hDEAD_BEEF));
        check_value("fl_wr", 128'(mem_wr_en), 128'(1));
        check_value("fl_addr", 128'(mem_address), 128'(32'h0000_0040));
        check_value("fl_wdata", 128'(mem_wdata), 128'(32'hDEAD_BEEF));
        check_value("fl_op3", 128'(core_operation_in[7:6]), 128'(2'b00));
        core_flush_out        = 4'b1010;
        core_data_out[63:32]  = 32'h1111_1111;
        #1;
        check_value("fl_low_data", 128'(core_data_in[95:64]), 128'(32'h1111_1111));
        check_value("fl_low_wdata", 128'(mem_wdata), 128'(32'h1111_1111));
        core_flush_out        = 4'b1110;
        core_data_out[95:64]  = 32'h2222_2222;
        #1;
        check_value("fl_own_wdata", 128'(mem_wdata), 128'(32'h2222_2222));
        check_value("fl_own_addr", 128'(mem_address), 128'(32'h0000_0040));
        check_value("fl_own_data2", 128'(core_data_in[95:64]), 128'(32'h1111_1111));
        tick();

        // Owner drops its request in its last allowed cycle: one release only.
        req_core = 4'b1111;
        zero_inputs();
        pulse_reset();
        for (int t = 0; t < MH; t++) tick();
        check_value("lim_owner", 128'(grant), 128'(4'b0001));
        req_core = 4'b1110;
        tick();
        check_value("lim_release", 128'(grant), 128'(4'b0000));
        tick();
        check_value("lim_next", 128'(grant), 128'(4'b0010));

        // Randomised traffic with occasional asynchronous resets.
        for (int c = 0; c < 800; c++) begin
            randomize_inputs();
            if ($urandom_range(149) == 0) pulse_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compare_count, mismatch_count);
        $finish;
    end

endmodule
